// File: rtl/audio_pkg.sv
// Shared types and constants for the audio voice sample fetcher.
package audio_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WAIT,
        ST_STOPPING
    } fetch_state_e;

endpackage

// File: rtl/audio_sync_fifo.sv
// Synchronous word FIFO with first-word fall-through head, flush and occupancy count.
module audio_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign rdata  = mem[rd_ptr];

    // Pointers and count; flush empties the queue in one cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/audio_sample_fetcher.sv
// Read-side DMA for one audio voice: fetches 32-bit words over AXI-Lite and
// streams them out as 16-bit PCM samples, low half first.
module audio_sample_fetcher
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_WIDTH  = 24
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   cfg_start_addr,
    input  logic [LEN_WIDTH-1:0]    cfg_length,
    input  logic                    cfg_loop,
    input  logic                    start,
    input  logic                    stop,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state, state_n;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
    logic [ADDR_WIDTH-1:0] start_addr, start_addr_n;
    logic [LEN_WIDTH-1:0]  length, length_n;
    logic [LEN_WIDTH-1:0]  remaining, remaining_n;
    logic                  loop_en, loop_n;
    logic                  stop_req, stop_req_n;
    logic                  err_n;
    logic                  done_pending, done_pending_n;
    logic                  half;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  out_fire;
    logic                  slot_after_push;

    audio_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .flush   (stop),
        .push    (fifo_push),
        .wdata   (m_axil_rdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign m_axil_arprot = 3'b000;
    assign m_axil_araddr = cur_addr;
    assign out_valid     = !fifo_empty;
    assign out_fire      = out_valid && out_ready;
    assign fifo_pop      = out_fire && half;
    assign busy          = (state != ST_IDLE) || !fifo_empty;
    assign done          = done_pending && !busy;
    assign out_sample    = fifo_empty ? '0
                         : (half ? fifo_rdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]
                                 : fifo_rdata[SAMPLE_WIDTH-1:0]);

    // A free slot must remain after this cycle's push (and any pop) to issue the next read.
    assign slot_after_push = (fifo_count - CNT_W'(fifo_pop)) < CNT_W'(FIFO_DEPTH - 1);

    always_comb begin
        state_n        = state;
        cur_addr_n     = cur_addr;
        start_addr_n   = start_addr;
        length_n       = length;
        remaining_n    = remaining;
        loop_n         = loop_en;
        stop_req_n     = stop_req;
        err_n          = err;
        done_pending_n = done_pending && busy;
        fifo_push      = 1'b0;

        if (stop) begin
            done_pending_n = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                if (start && !stop && !busy && (cfg_length != '0)) begin
                    start_addr_n   = cfg_start_addr;
                    cur_addr_n     = cfg_start_addr;
                    length_n       = cfg_length;
                    remaining_n    = cfg_length;
                    loop_n         = cfg_loop;
                    err_n          = 1'b0;
                    stop_req_n     = 1'b0;
                    done_pending_n = 1'b0;
                    state_n        = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // arvalid cannot be withdrawn, so a stop waits for the handshake.
                if (m_axil_arready) begin
                    state_n    = (stop || stop_req) ? ST_STOPPING : ST_DATA;
                    stop_req_n = 1'b0;
                end else if (stop) begin
                    stop_req_n = 1'b1;
                end
            end
            ST_DATA: begin
                if (stop) begin
                    state_n = m_axil_rvalid ? ST_IDLE : ST_STOPPING;
                end else if (m_axil_rvalid) begin
                    if (m_axil_rresp != RESP_OKAY) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        fifo_push = 1'b1;
                        state_n   = slot_after_push ? ST_ADDR : ST_WAIT;
                        if (remaining == LEN_WIDTH'(1)) begin
                            if (loop_en) begin
                                cur_addr_n  = start_addr;
                                remaining_n = length;
                            end else begin
                                state_n        = ST_IDLE;
                                done_pending_n = 1'b1;
                            end
                        end else begin
                            cur_addr_n  = cur_addr + ADDR_WIDTH'(1);
                            remaining_n = remaining - LEN_WIDTH'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (!fifo_full || fifo_pop) begin
                    state_n = ST_ADDR;
                end
            end
            ST_STOPPING: begin
                if (m_axil_rvalid) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            start_addr     <= '0;
            length         <= '0;
            remaining      <= '0;
            loop_en        <= 1'b0;
            stop_req       <= 1'b0;
            err            <= 1'b0;
            done_pending   <= 1'b0;
            half           <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            state          <= state_n;
            cur_addr       <= cur_addr_n;
            start_addr     <= start_addr_n;
            length         <= length_n;
            remaining      <= remaining_n;
            loop_en        <= loop_n;
            stop_req       <= stop_req_n;
            err            <= err_n;
            done_pending   <= done_pending_n;
            m_axil_arvalid <= (state_n == ST_ADDR);
            m_axil_rready  <= (state_n == ST_DATA) || (state_n == ST_STOPPING);
            if (stop) begin
                half <= 1'b0;
            end else if (out_fire) begin
                half <= ~half;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Self-checking bench for audio_sample_fetcher: randomized AXI-Lite slave plus
// a reference model of the expected address and sample sequences.
module tb_audio_sample_fetcher;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_start_addr;
    logic [23:0] cfg_length;
    logic        cfg_loop;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        m_axil_rready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;

    always #5 aclk = ~aclk;

    audio_sample_fetcher dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_start_addr (cfg_start_addr),
        .cfg_length     (cfg_length),
        .cfg_loop       (cfg_loop),
        .start          (start),
        .stop           (stop),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (s_arready),
        .m_axil_rdata   (s_rdata),
        .m_axil_rresp   (s_rresp),
        .m_axil_rvalid  (s_rvalid),
        .m_axil_rready  (m_axil_rready),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [256];

    // Reference model of the current run
    logic [31:0] run_start;
    int          run_len;
    bit          run_loop;
    int          err_word;
    int          max_smp;
    int          n_ar;
    int          n_smp;
    int          n_done;

    // Slave model state
    bit          have_ar;
    logic [31:0] ar_addr;
    bit          ar_err;
    int          delay;
    int          hold;
    bit          rand_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sample();
        int          w;
        logic [31:0] a;
        logic [31:0] word;
        logic [15:0] e;
        chk("sample_within_run", 32'(n_smp < max_smp), 32'd1);
        if (n_smp < max_smp) begin
            w = n_smp / 2;
            if (run_loop) w = w % run_len;
            a    = run_start + 32'(w);
            word = mem[a[7:0]];
            e    = (n_smp % 2 == 1) ? word[31:16] : word[15:0];
            chk("sample", 32'(out_sample), 32'(e));
        end
        n_smp++;
    endtask

    task automatic check_ar();
        int k;
        k = run_loop ? (n_ar % run_len) : n_ar;
        chk("araddr", m_axil_araddr, run_start + 32'(k));
        chk("arprot", 32'(m_axil_arprot), 32'd0);
        n_ar++;
    endtask

    // One clock: account for handshakes of the current cycle, then advance the slave.
    task automatic step();
        bit          ar_fire;
        bit          r_fire;
        logic [31:0] ar_a;
        ar_fire = aresetn && m_axil_arvalid && s_arready;
        r_fire  = aresetn && s_rvalid && m_axil_rready;
        ar_a    = m_axil_araddr;
        if (aresetn) begin
            if (out_valid && out_ready) check_sample();
            if (ar_fire) check_ar();
            if (done) begin
                n_done++;
                chk("done_while_busy", 32'(busy), 32'd0);
            end
        end
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            have_ar   = 1'b0;
            s_rvalid  = 1'b0;
            s_arready = 1'b0;
            s_rresp   = 2'b00;
        end else begin
            if (r_fire) begin
                s_rvalid = 1'b0;
                have_ar  = 1'b0;
            end
            if (ar_fire) begin
                have_ar = 1'b1;
                ar_addr = ar_a;
                ar_err  = ((n_ar - 1) == err_word);
                delay   = int'($urandom_range(0, 2));
            end
            if (have_ar && !s_rvalid) begin
                if (delay == 0) begin
                    s_rvalid = 1'b1;
                    s_rdata  = mem[ar_addr[7:0]];
                    s_rresp  = ar_err ? 2'b10 : 2'b00;
                end else begin
                    delay--;
                end
            end
            s_arready = !have_ar && (hold == 0) && ($urandom_range(0, 3) != 0);
            if (hold > 0) hold--;
        end
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_run(input logic [31:0] sa, input int len, input bit lp,
                             input int ew, input int ms);
        run_start      = sa;
        run_len        = len;
        run_loop       = lp;
        err_word       = ew;
        max_smp        = ms;
        n_ar           = 0;
        n_smp          = 0;
        n_done         = 0;
        cfg_start_addr = sa;
        cfg_length     = 24'(len);
        cfg_loop       = lp;
        start          = 1'b1;
        step();
        start          = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            step();
            i++;
        end
        chk("idle_within_budget", 32'(busy), 32'd0);
        step();
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_arvalid"},   32'(m_axil_arvalid), 32'd0);
        chk({tag, "_rready"},    32'(m_axil_rready),  32'd0);
        chk({tag, "_araddr"},    m_axil_araddr,       32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid),      32'd0);
        chk({tag, "_out_sample"},32'(out_sample),     32'd0);
        chk({tag, "_busy"},      32'(busy),           32'd0);
        chk({tag, "_done"},      32'(done),           32'd0);
        chk({tag, "_err"},       32'(err),            32'd0);
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; stop = 1'b0; cfg_start_addr = '0; cfg_length = '0;
        cfg_loop = 1'b0; s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
        out_ready = 1'b1; have_ar = 1'b0; ar_addr = '0; ar_err = 1'b0; delay = 0; hold = 0;
        rand_ready = 1'b0; err_word = -1; run_len = 1; run_loop = 1'b0; run_start = '0;
        max_smp = 0; n_ar = 0; n_smp = 0; n_done = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        step(); step();
        check_reset_vals("reset");
        aresetn = 1'b1;
        step();

        // Directed one-shot run
        mem[8'h10] = 32'h0002_0001; mem[8'h11] = 32'h0004_0003; mem[8'h12] = 32'h0006_0005;
        start_run(32'h10, 3, 1'b0, -1, 6);
        chk("t1_arvalid_after_start", 32'(m_axil_arvalid), 32'd1);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        wait_idle(200);
        chk("t1_samples", 32'(n_smp), 32'd6);
        chk("t1_ar_count", 32'(n_ar), 32'd3);
        chk("t1_done_count", 32'(n_done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Randomized one-shot runs with random backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            int len;
            len = int'($urandom_range(1, 10));
            start_run(32'($urandom_range(0, 240)), len, 1'b0, -1, 2 * len);
            chk("rnd_arvalid_after_start", 32'(m_axil_arvalid), 32'd1);
            wait_idle(600);
            chk("rnd_samples", 32'(n_smp), 32'(2 * len));
            chk("rnd_ar_count", 32'(n_ar), 32'(len));
            chk("rnd_done_count", 32'(n_done), 32'd1);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Looped playback, ended by stop
        start_run(32'h10, 3, 1'b1, -1, 1 << 30);
        for (int i = 0; i < 80; i++) step();
        chk("loop_wrapped", 32'(n_ar >= 7), 32'd1);
        chk("loop_samples_flowing", 32'(n_smp >= 12), 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(50);
        chk("loop_out_valid_after_stop", 32'(out_valid), 32'd0);
        chk("loop_no_done", 32'(n_done), 32'd0);

        // Backpressure fills the FIFO and parks the fetcher
        out_ready = 1'b0;
        start_run(32'h40, 12, 1'b0, -1, 24);
        for (int i = 0; i < 80; i++) step();
        chk("wait_ar_count", 32'(n_ar), 32'd8);
        chk("wait_arvalid", 32'(m_axil_arvalid), 32'd0);
        chk("wait_rready", 32'(m_axil_rready), 32'd0);
        chk("wait_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_idle(300);
        chk("wait_samples", 32'(n_smp), 32'd24);
        chk("wait_ar_total", 32'(n_ar), 32'd12);
        chk("wait_done_count", 32'(n_done), 32'd1);

        // Error response on the second word
        start_run(32'h80, 4, 1'b0, 1, 2);
        wait_idle(200);
        chk("err_flag", 32'(err), 32'd1);
        chk("err_ar_count", 32'(n_ar), 32'd2);
        chk("err_samples", 32'(n_smp), 32'd2);
        chk("err_no_done", 32'(n_done), 32'd0);
        start_run(32'h20, 2, 1'b0, -1, 4);
        chk("err_cleared_by_start", 32'(err), 32'd0);
        wait_idle(200);
        chk("after_err_done", 32'(n_done), 32'd1);

        // Stop while the address phase is stalled by the slave
        hold = 8;
        start_run(32'h30, 4, 1'b0, -1, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stop_arvalid_held", 32'(m_axil_arvalid), 32'd1);
            step();
        end
        wait_idle(100);
        chk("stop_ar_count", 32'(n_ar), 32'd1);
        chk("stop_out_valid", 32'(out_valid), 32'd0);
        chk("stop_no_done", 32'(n_done), 32'd0);

        // Reset in the middle of a data phase
        start_run(32'h50, 8, 1'b0, -1, 16);
        for (int i = 0; i < 20 && !m_axil_rready; i++) step();
        chk("rst_reached_data", 32'(m_axil_rready), 32'd1);
        aresetn = 1'b0;
        step();
        check_reset_vals("midrst");
        aresetn = 1'b1;
        step();

        // Zero-length start is ignored
        start_run(32'h60, 0, 1'b0, -1, 0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_arvalid", 32'(m_axil_arvalid), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("len0_ar_count", 32'(n_ar), 32'd0);
        chk("len0_busy_later", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
